// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx
//  Purpose  : Serial receiver for the UART line (start, 8 data bits LSB
//             first, odd parity, one stop bit, idle high). Recovers the
//             byte, flags parity and framing errors and pulses a one-cycle
//             strobe per completed frame.
//  Ports    : clk        - system clock
//             Reset      - synchronous, active-high reset
//             Sin        - asynchronous serial line, idle high
//             Dout[7:0]  - last received byte, held until the next frame
//             Received   - one-cycle strobe: Dout/ParityErr/FrameErr valid
//             ParityErr  - parity check failed for the frame in Dout
//             FrameErr   - stop bit sampled 0 for the frame in Dout
//             Busy       - high in every state except IDLE
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int CLKS_PER_BIT = 5209,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       Sin,
    output logic [7:0] Dout,
    output logic       Received,
    output logic       ParityErr,
    output logic       FrameErr,
    output logic       Busy
);

    // Timer is at least 13 bits wide, wider only if the bit period needs it.
    localparam int TW = ($clog2(CLKS_PER_BIT) > 13) ? $clog2(CLKS_PER_BIT) : 13;

    localparam logic [TW-1:0] c_half_tc = TW'(HALF_BIT - 1);
    localparam logic [TW-1:0] c_bit_tc  = TW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        BITS    = 3'd2,
        PAR     = 3'd3,
        STOP    = 3'd4,
        DONE    = 3'd5,
        WAIT_HI = 3'd6
    } state_t;

    state_t          state_q,      state_d;
    logic [TW-1:0]   timer_q,      timer_d;
    logic [2:0]      bit_idx_q,    bit_idx_d;
    logic [7:0]      shift_q,      shift_d;
    logic            par_q,        par_d;
    logic            stop_q,       stop_d;
    logic [7:0]      dout_q,       dout_d;
    logic            received_q,   received_d;
    logic            parity_err_q, parity_err_d;
    logic            frame_err_q,  frame_err_d;
    logic            busy_q,       busy_d;
    logic            sync1_q;
    logic            sin_s_q;
    logic            w_tc;

    // Half-bit terminal count in START lands the later samples at mid-bit.
    assign w_tc = (state_q == START) ? (timer_q == c_half_tc)
                                     : (timer_q == c_bit_tc);

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q + 1'b1;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        par_d        = par_q;
        stop_d       = stop_q;
        dout_d       = dout_q;
        received_d   = 1'b0;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;

        case (state_q)
            IDLE: begin
                if (!sin_s_q) begin
                    state_d = START;
                end
            end
            START: begin
                if (w_tc) begin
                    if (!sin_s_q) begin
                        state_d   = BITS;
                        bit_idx_d = 3'd0;
                    end else begin
                        // Line went back high before mid-start: false start.
                        state_d = IDLE;
                    end
                end
            end
            BITS: begin
                if (w_tc) begin
                    // LSB arrives first, so shift in from the top.
                    shift_d = {sin_s_q, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = PAR;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            PAR: begin
                if (w_tc) begin
                    par_d   = sin_s_q;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (w_tc) begin
                    // Results are registered on entry so they are valid for
                    // the whole single DONE cycle together with the strobe.
                    stop_d       = sin_s_q;
                    dout_d       = shift_q;
                    parity_err_d = (par_q != ~^shift_q);
                    frame_err_d  = ~sin_s_q;
                    received_d   = 1'b1;
                    state_d      = DONE;
                end
            end
            DONE: begin
                // A low stop bit means the line may be stuck low (break);
                // wait for it to return high before hunting for a start.
                state_d = stop_q ? IDLE : WAIT_HI;
            end
            WAIT_HI: begin
                if (sin_s_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Timer restarts on every terminal count and state change, and
        // is held at zero while idle.
        if (w_tc || (state_d != state_q) || (state_q == IDLE)) begin
            timer_d = '0;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            bit_idx_q    <= 3'd0;
            shift_q      <= 8'd0;
            par_q        <= 1'b0;
            stop_q       <= 1'b0;
            dout_q       <= 8'd0;
            received_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
            sync1_q      <= 1'b1;
            sin_s_q      <= 1'b1;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            par_q        <= par_d;
            stop_q       <= stop_d;
            dout_q       <= dout_d;
            received_q   <= received_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            busy_q       <= busy_d;
            sync1_q      <= Sin;
            sin_s_q      <= sync1_q;
        end
    end

    assign Dout      = dout_q;
    assign Received  = received_q;
    assign ParityErr = parity_err_q;
    assign FrameErr  = frame_err_q;
    assign Busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx
//  Purpose  : Self-checking bench for uart_rx. A bit-timed line driver sends
//             frames; each frame's expected byte, error flags and mid-stop
//             time are queued from the frame definition and compared against
//             every Received pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    localparam int CPB  = 16;
    localparam int HALF = 8;

    logic       clk;
    logic       Reset;
    logic       Sin;
    logic [7:0] Dout;
    logic       Received;
    logic       ParityErr;
    logic       FrameErr;
    logic       Busy;

    uart_rx #(
        .CLKS_PER_BIT (CPB),
        .HALF_BIT     (HALF)
    ) dut (
        .clk       (clk),
        .Reset     (Reset),
        .Sin       (Sin),
        .Dout      (Dout),
        .Received  (Received),
        .ParityErr (ParityErr),
        .FrameErr  (FrameErr),
        .Busy      (Busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        logic       pe;
        logic       fe;
        int         mid;
    } exp_t;

    exp_t exp_q[$];
    int   tests_run    = 0;
    int   tests_failed = 0;
    int   rx_count     = 0;
    int   exp_rx       = 0;
    logic prev_rcv     = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests_run++;
        if (obs !== exp_v) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    // Monitor: every strobe must match the oldest outstanding frame.
    always @(negedge clk) begin
        if (Received) begin
            check("rx_single", 32'(prev_rcv), 32'd0);
            if (exp_q.size() == 0) begin
                check("rx_unexpected", 32'd1, 32'd0);
            end else begin
                exp_t e;
                int   lat;
                e   = exp_q.pop_front();
                lat = cyc - e.mid;
                check("rx_dout", 32'(Dout), 32'(e.data));
                check("rx_parity_err", 32'(ParityErr), 32'(e.pe));
                check("rx_frame_err", 32'(FrameErr), 32'(e.fe));
                check("rx_latency_ok", 32'((lat >= 2) && (lat <= 4)), 32'd1);
            end
            rx_count++;
        end
        prev_rcv = Received;
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        Sin = b;
        wait_cycles(CPB);
    endtask

    // Sends one frame; the expectation is queued at the start of the stop
    // bit, when its mid-point time is known.
    task automatic send_frame(input logic [7:0] data, input logic par, input logic stop);
        exp_t e;
        logic good_par;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(data[i]);
        drive_bit(par);
        // Odd parity: data ones plus parity bit must total an odd number.
        good_par = ($countones(data) % 2 == 0);
        e.data = data;
        e.pe   = (par != good_par);
        e.fe   = ~stop;
        e.mid  = cyc + HALF;
        exp_q.push_back(e);
        exp_rx++;
        drive_bit(stop);
    endtask

    function automatic logic odd_par(input logic [7:0] d);
        return ($countones(d) % 2 == 0);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1;
        Sin   = 1'b1;
        wait_cycles(3);
        check("reset_dout", 32'(Dout), 32'd0);
        check("reset_received", 32'(Received), 32'd0);
        check("reset_parity_err", 32'(ParityErr), 32'd0);
        check("reset_frame_err", 32'(FrameErr), 32'd0);
        check("reset_busy", 32'(Busy), 32'd0);
        Reset = 1'b0;
        wait_cycles(20);

        // Clean frame.
        send_frame(8'hA5, 1'b1, 1'b1);
        wait_cycles(32);
        check("a5_count", 32'(rx_count), 32'd1);
        check("a5_busy_low", 32'(Busy), 32'd0);

        // Back-to-back frames, no idle gap.
        send_frame(8'h07, 1'b0, 1'b1);
        send_frame(8'h00, 1'b1, 1'b1);
        wait_cycles(32);
        check("b2b_count", 32'(rx_count), 32'd3);
        check("b2b_dout", 32'(Dout), 32'h00);

        // Wrong parity bit.
        send_frame(8'h3C, 1'b0, 1'b1);
        wait_cycles(32);
        check("par_count", 32'(rx_count), 32'd4);
        check("par_flag", 32'(ParityErr), 32'd1);

        // Low stop bit with the line held low afterwards.
        send_frame(8'h81, 1'b1, 1'b0);
        Sin = 1'b0;
        wait_cycles(40);
        check("break_count", 32'(rx_count), 32'd5);
        check("break_busy_high", 32'(Busy), 32'd1);
        check("break_frame_err", 32'(FrameErr), 32'd1);
        Sin = 1'b1;
        wait_cycles(32);
        check("break_recovered", 32'(Busy), 32'd0);
        send_frame(8'h55, 1'b1, 1'b1);
        wait_cycles(32);
        check("after_break_count", 32'(rx_count), 32'd6);
        check("after_break_fe", 32'(FrameErr), 32'd0);

        // Short low glitch while idle.
        Sin = 1'b0;
        wait_cycles(3);
        Sin = 1'b1;
        wait_cycles(32);
        check("glitch_count", 32'(rx_count), 32'd6);
        check("glitch_busy", 32'(Busy), 32'd0);
        check("glitch_dout", 32'(Dout), 32'h55);

        // Reset in the middle of bit 4 of an all-ones byte.
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        wait_cycles(HALF);
        Reset = 1'b1;
        wait_cycles(1);
        Reset = 1'b0;
        check("midrst_dout", 32'(Dout), 32'd0);
        check("midrst_received", 32'(Received), 32'd0);
        check("midrst_parity_err", 32'(ParityErr), 32'd0);
        check("midrst_frame_err", 32'(FrameErr), 32'd0);
        check("midrst_busy", 32'(Busy), 32'd0);
        wait_cycles(40);
        check("midrst_count", 32'(rx_count), 32'd6);
        send_frame(8'h12, 1'b1, 1'b1);
        wait_cycles(32);
        check("midrst_next_count", 32'(rx_count), 32'd7);
        check("midrst_next_dout", 32'(Dout), 32'h12);

        // Randomized frames with occasional parity/stop faults and gaps.
        for (int n = 0; n < 24; n++) begin
            logic [7:0] d;
            logic       p;
            logic       s;
            d = 8'($urandom);
            p = odd_par(d);
            if ($urandom_range(0, 3) == 0) p = ~p;
            s = ($urandom_range(0, 5) != 0);
            send_frame(d, p, s);
            if (!s) begin
                Sin = 1'b0;
                wait_cycles(20);
                Sin = 1'b1;
                wait_cycles(24);
            end else begin
                Sin = 1'b1;
                wait_cycles($urandom_range(0, 20));
            end
        end
        wait_cycles(64);
        check("rand_count", 32'(rx_count), 32'(exp_rx));
        check("rand_pending", 32'(exp_q.size()), 32'd0);
        check("final_busy", 32'(Busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver; the consuming stage for the team's UART transmitter line (Sout).
- Frame format: start bit (0), 8 data bits LSB first, odd-parity bit, one stop bit (1), idle high. The parity bit equals XNOR-reduce of the data.
- Recovers the byte, flags parity and framing errors, and pulses a strobe per completed frame for downstream logic.

Parameters:
- CLKS_PER_BIT, 5209, clk cycles per bit period (100 MHz / 19200 baud; matches the transmitter's 0..5208 timer).
- HALF_BIT, CLKS_PER_BIT/2 (integer floor), cycles from start-edge detection to start-bit mid-sample.

Ports:
- clk  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- Sin  in  1  asynchronous serial line, idle high
- Dout  out  8  last received byte; held until the next frame completes
- Received  out  1  one-cycle strobe: frame complete, Dout/ParityErr/FrameErr valid
- ParityErr  out  1  parity check failed for the frame in Dout; held with Dout
- FrameErr  out  1  stop bit sampled 0 for the frame in Dout; held with Dout
- Busy  out  1  high in every state except IDLE

Behaviour:
- Clock and reset: clk, Reset; Reset is synchronous, active-high.
- Reset: state=IDLE; Dout=0, Received=0, ParityErr=0, FrameErr=0, Busy=0; timer=0, bit index=0; both sync flops=1.
- Input: Sin passes through a 2-flop synchronizer (sin_s). All decisions use sin_s. The 2-cycle lag is tolerated.
- Timer: 13-bit minimum, counts up every cycle and is cleared on every state change. A terminal count (tc) occurs at HALF_BIT-1 in START and at CLKS_PER_BIT-1 in BITS, PAR and STOP.
- States:
  - IDLE: timer held at 0. sin_s==0 -> START.
  - START: at tc, sample sin_s. If 0 -> BITS with bit index cleared. If 1 (glitch/false start) -> IDLE, no strobe, outputs unchanged.
  - BITS: at tc, shift sin_s into the shift register at the MSB (LSB-first arrival). If index==7 -> PAR; else index+1 and stay in BITS.
  - PAR: at tc, capture the parity bit -> STOP.
  - STOP: at tc, sample the stop bit -> DONE.
  - DONE: lasts exactly one cycle.
    - Dout <= shift register.
    - ParityErr <= (parity bit != ~^data).
    - FrameErr <= (stop sample==0).
    - Received=1 this cycle only.
    - Next state: WAIT_HI if the stop sample was 0, else IDLE.
  - WAIT_HI: stays until sin_s==1 (break/line-low recovery), then -> IDLE. Prevents a stuck-low line from re-triggering frames.
- Sample timing: each data, parity and stop sample lands at nominal mid-bit (HALF_BIT + n*CLKS_PER_BIT cycles after the start edge, plus sync delay).
- Latency: Received asserts 2-4 cycles after the mid-stop-bit point of Sin (sync + tc + DONE). Back-to-back frames with no idle gap must be received.
- Dout, ParityErr and FrameErr change only in DONE. Received is never asserted for two consecutive cycles.
- Errored frames still update Dout and assert Received; downstream decides whether to discard.
- Reset mid-frame: returns to IDLE on the next edge, and all outputs clear per the reset values. The remainder of the interrupted frame may be seen as a false start only if sin_s is 0; the START mid-sample rule then applies.
- Illegal/unused state encodings -> IDLE.

Test Plan:
(Simulate with CLKS_PER_BIT=16, HALF_BIT=8; the stimulus driver models the transmitter's bit timing.)
- Reset, line idle, then frame 0xA5 (parity bit 1, stop 1) -> one Received pulse; Dout=0xA5, ParityErr=0, FrameErr=0; Busy low afterwards.
- Frames 0x07 (parity 0) then 0x00 (parity 1), back-to-back with no idle gap -> two pulses; Dout=0x07, then 0x00; no errors.
- Frame 0x3C sent with parity bit 0 (wrong; correct is 1) -> Received pulses; Dout=0x3C; ParityErr=1; FrameErr=0.
- Frame 0x81 with stop bit 0, line held low 40 cycles, then high -> Received with FrameErr=1. No further pulse while low; stays in WAIT_HI; next valid frame 0x55 is received cleanly with FrameErr=0.
- 3-cycle low glitch on Sin while idle -> no Received; state returns to IDLE; Dout unchanged.
- Reset asserted during bit 4 of frame 0xFF, line then held high -> all outputs 0; no Received; next frame 0x12 is received correctly.
